// File: rtl/ntsc_sync_gen_if.sv
// rtl/ntsc_sync_gen_if.sv - pixel ready/valid handshake between an upstream pixel source and ntsc_sync_gen
//
// Signals:
//   pix_data   upstream pixel code (4-bit DAC code before black clamp)
//   pix_valid  pix_data is valid this cycle
//   pix_ready  sync generator consumes a pixel this cycle
//   pix_x      active column index of the pixel being consumed (0 outside active)
//   pix_y      active row index of the pixel being consumed (0 outside active)
//
// Modports:
//   master  pixel source: drives data/valid, observes ready and coordinates
//   slave   sync generator: observes data/valid, drives ready and coordinates

interface ntsc_sync_gen_if;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [7:0] pix_y;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  pix_x,
        input  pix_y
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output pix_x,
        output pix_y
    );
endinterface

// File: rtl/ntsc_sync_gen.sv
// rtl/ntsc_sync_gen.sv - 262-line progressive NTSC-style sync/timing generator driving the 4-bit video DAC
//
// Ports:
//   clk           video clock, all logic on its rising edge
//   NRST          synchronous active-low reset
//   en            run enable; low restarts the frame at line 0, clock 0
//   pix           pixel handshake (slave side): pix_data/pix_valid in,
//                 pix_ready/pix_x/pix_y out
//   underrun_clr  clears the sticky underrun flag
//   underrun      sticky flag: an active pixel slot found no valid pixel
//   line_start    one-cycle pulse while vdac shows clock 0 of a line
//   frame_start   one-cycle pulse while vdac shows clock 0 of line 0
//   vdac          registered DAC code, sole driver of the DAC pins

module ntsc_sync_gen #(
    parameter int         H_TOTAL     = 1016,
    parameter int         H_SYNC      = 76,
    parameter int         H_ACT_START = 168,
    parameter int         H_ACT       = 816,
    parameter int         V_TOTAL     = 262,
    parameter int         V_ACT_START = 22,
    parameter int         V_ACT       = 240,
    parameter logic [3:0] SYNC_LVL    = 4'd0,
    parameter logic [3:0] BLANK_LVL   = 4'd4,
    parameter logic [3:0] BLACK_LVL   = 4'd5
) (
    input  logic                  clk,
    input  logic                  NRST,
    input  logic                  en,
    ntsc_sync_gen_if.slave        pix,
    input  logic                  underrun_clr,
    output logic                  underrun,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [3:0]            vdac
);

    // Parameter sanity: sync and active video must not overlap and the
    // active window must fit inside the line/frame.
    if (H_ACT_START < H_SYNC) begin : g_bad_h_start
        $error("ntsc_sync_gen: H_ACT_START must not be below H_SYNC");
    end
    if (H_ACT_START + H_ACT > H_TOTAL) begin : g_bad_h_act
        $error("ntsc_sync_gen: active video runs past end of line");
    end
    if (V_ACT_START + V_ACT > V_TOTAL) begin : g_bad_v_act
        $error("ntsc_sync_gen: active lines run past end of frame");
    end
    if ((H_SYNC % 2) != 0) begin : g_bad_h_sync
        $error("ntsc_sync_gen: H_SYNC must be even");
    end

    // Counter widths leave room for the exclusive end bounds.
    localparam int H_W    = $clog2(H_TOTAL + 1);
    localparam int V_W    = $clog2(V_TOTAL + 1);
    localparam int H_HALF = H_TOTAL / 2;

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_HALF_C    = H_W'(H_HALF);
    localparam logic [H_W-1:0] EQ1_END     = H_W'(H_SYNC / 2);
    localparam logic [H_W-1:0] EQ2_END     = H_W'(H_HALF + H_SYNC / 2);
    localparam logic [H_W-1:0] BROAD1_END  = H_W'(H_HALF - H_SYNC);
    localparam logic [H_W-1:0] BROAD2_END  = H_W'(H_TOTAL - H_SYNC);
    localparam logic [H_W-1:0] HSYNC_END   = H_W'(H_SYNC);
    localparam logic [H_W-1:0] HACT_BEG    = H_W'(H_ACT_START);
    localparam logic [H_W-1:0] HACT_END    = H_W'(H_ACT_START + H_ACT);

    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] VACT_BEG    = V_W'(V_ACT_START);
    localparam logic [V_W-1:0] VACT_END    = V_W'(V_ACT_START + V_ACT);
    // Vertical interval layout: equalizing 0-2, broad 3-5, equalizing 6-8.
    localparam logic [V_W-1:0] V_EQ1_LAST  = V_W'(2);
    localparam logic [V_W-1:0] V_BROAD_BEG = V_W'(3);
    localparam logic [V_W-1:0] V_BROAD_END = V_W'(5);
    localparam logic [V_W-1:0] V_EQ2_BEG   = V_W'(6);
    localparam logic [V_W-1:0] V_EQ2_LAST  = V_W'(8);

    typedef enum logic [1:0] {
        LINE_NORMAL,
        LINE_EQ,
        LINE_BROAD
    } line_kind_t;

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;

    line_kind_t     line_kind;
    logic           sync;
    logic           act_win;
    logic           act;
    logic           starve;
    logic [3:0]     pix_clamped;
    logic [3:0]     vdac_nxt;

    // ------------------------------------------------------------------
    // Horizontal / vertical counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!NRST || !en) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line classification and sync decode
    // ------------------------------------------------------------------
    always_comb begin
        line_kind = LINE_NORMAL;
        if ((v <= V_EQ1_LAST) || ((v >= V_EQ2_BEG) && (v <= V_EQ2_LAST))) begin
            line_kind = LINE_EQ;
        end else if ((v >= V_BROAD_BEG) && (v <= V_BROAD_END)) begin
            line_kind = LINE_BROAD;
        end
    end

    // Equalizing and broad lines carry two pulses per line, one in each
    // half-line; normal lines carry a single hsync at the start.
    always_comb begin
        sync = 1'b0;
        case (line_kind)
            LINE_EQ:
                sync = (h < EQ1_END) || ((h >= H_HALF_C) && (h < EQ2_END));
            LINE_BROAD:
                sync = (h < BROAD1_END) || ((h >= H_HALF_C) && (h < BROAD2_END));
            default:
                sync = (h < HSYNC_END);
        endcase
    end

    // ------------------------------------------------------------------
    // Active window and pixel handshake
    // ------------------------------------------------------------------
    assign act_win = (v >= VACT_BEG) && (v < VACT_END) &&
                     (h >= HACT_BEG) && (h < HACT_END);

    // Ready is masked by en so that a pixel is never taken on an edge that
    // discards it by restarting the frame.
    assign act = act_win && en;

    assign pix.pix_ready = act;
    assign pix.pix_x     = act ? 10'(h - HACT_BEG) : 10'd0;
    assign pix.pix_y     = act ? 8'(v - VACT_BEG)  : 8'd0;

    assign starve      = act && !pix.pix_valid;
    assign pix_clamped = (pix.pix_data < BLACK_LVL) ? BLACK_LVL : pix.pix_data;

    // Sync always wins; active slots show the clamped pixel or black when
    // starved; everything else is blanking.
    always_comb begin
        vdac_nxt = BLANK_LVL;
        if (sync) begin
            vdac_nxt = SYNC_LVL;
        end else if (act) begin
            vdac_nxt = pix.pix_valid ? pix_clamped : BLACK_LVL;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!NRST) begin
            vdac        <= BLANK_LVL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!en) begin
            // underrun deliberately keeps its value across a restart.
            vdac        <= BLANK_LVL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vdac        <= vdac_nxt;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
            if (starve) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ntsc_sync_gen.md
# ntsc_sync_gen

Generates NTSC-style 262-line progressive (240p) composite timing and sequences the 4-bit video DAC code in the `ntsc_out_top` design. It runs in the PLL-derived `clk` domain at 16 MHz nominal and owns horizontal/vertical counters and sync/equalizing/broad-pulse decode. It also pulls active-video pixels from an upstream source through a ready/valid handshake. Its `vdac` output is the sole driver of the top-level DAC pins.

## Interface
- `H_TOTAL`, 1016, clocks per line (63.5 µs at 16 MHz).
- `H_SYNC`, 76, normal hsync width in clocks; must be even.
- `H_ACT_START`, 168, first active clock of a line.
- `H_ACT`, 816, active clocks per line.
- `V_TOTAL`, 262, lines per frame.
- `V_ACT_START`, 22, first active line.
- `V_ACT`, 240, active lines.
- `SYNC_LVL`, 4'd0, DAC code for sync tip.
- `BLANK_LVL`, 4'd4, DAC code for blanking.
- `BLACK_LVL`, 4'd5, minimum DAC code for active video.
- `clk`  in  1  video clock; all logic on its rising edge.
- `NRST`  in  1  reset, synchronous, active-low; clock clk.
- `en`  in  1  run enable; low forces a synchronous restart.
- `pix_data`  in  4  upstream pixel code.
- `pix_valid`  in  1  `pix_data` is valid.
- `pix_ready`  out  1  block consumes a pixel this cycle.
- `pix_x`  out  10  active column index; 0 outside active.
- `pix_y`  out  8  active row index; 0 outside active.
- `underrun_clr`  in  1  clears `underrun`.
- `underrun`  out  1  sticky pixel-starvation flag.
- `line_start`  out  1  one-cycle pulse per line.
- `frame_start`  out  1  one-cycle pulse per frame.
- `vdac`  out  4  registered DAC code.

## Operation
- Counters:
  - `h` runs 0..H_TOTAL-1 and wraps to 0.
  - `v` increments on each `h` wrap and runs 0..V_TOTAL-1 before wrapping.
  - Both reset to 0.
- Line types and sync decode (h2 = H_TOTAL/2):
  - Lines 0-2 and 6-8 are equalizing lines. Sync is active for h < H_SYNC/2 or h2 ≤ h < h2+H_SYNC/2.
  - Lines 3-5 are broad-pulse lines. Sync is active for h < h2-H_SYNC or h2 ≤ h < H_TOTAL-H_SYNC.
  - All other lines are normal lines. Sync is active for h < H_SYNC.
- Active region: `act` = (V_ACT_START ≤ v < V_ACT_START+V_ACT) and (H_ACT_START ≤ h < H_ACT_START+H_ACT).
  - Sync and active never overlap. Elaboration must fail if H_ACT_START < H_SYNC, H_ACT_START+H_ACT > H_TOTAL, or V_ACT_START+V_ACT > V_TOTAL.
- `vdac` next value, in priority order:
  - sync → SYNC_LVL;
  - act & pix_valid → max(pix_data, BLACK_LVL);
  - act & !pix_valid → BLACK_LVL, and `underrun` is set;
  - otherwise → BLANK_LVL.
- Handshake and pixel coordinates:
  - `pix_ready` = `act`, decoded from the registered counters.
  - A pixel is consumed iff `pix_ready & pix_valid`. The upstream must not hold data across a ready cycle.
  - `pix_x` = h-H_ACT_START and `pix_y` = v-V_ACT_START while `act` is high; both are 0 otherwise. They are valid in the same cycle as `pix_ready`.
- `underrun`:
  - Set on `pix_ready & !pix_valid`.
  - Cleared by `underrun_clr`.
  - Set has priority when both occur in the same cycle.
- `en` low, sampled at an edge:
  - `h` and `v` go to 0.
  - `vdac` goes to BLANK_LVL; `pix_ready`, `line_start` and `frame_start` are 0.
  - `underrun` is held.
  - When `en` rises, counting resumes from line 0, clock 0.

## Timing
- Reset (NRST=0 at an edge) sets `h`=0, `v`=0, `vdac`=BLANK_LVL, `underrun`=0, `line_start`=0 and `frame_start`=0.
  - `pix_ready`=0, `pix_x`=0 and `pix_y`=0 follow from the counter values.
  - Reset mid-line aborts the line immediately.
- Latency: a decode made from (h,v) at edge t appears on `vdac` after edge t+1. A pixel consumed in cycle t is on `vdac` in cycle t+1.
- `line_start` is registered: it is high during the cycle in which `vdac` shows the h=0 value.
- `frame_start` is the same as `line_start` but only when v=0.
- Period: `line_start` every H_TOTAL clocks; `frame_start` every H_TOTAL×V_TOTAL clocks (266 192 at defaults).
- `underrun` rises in the cycle after the starved ready cycle.

## Test plan
- **Reset release.** Hold NRST=0 for 4 clocks with en=1, then release.
  - `vdac`=4 during reset.
  - The first post-reset cycle shows `vdac`=0 with `frame_start`=`line_start`=1.
  - `vdac`=0 holds for 38 clocks, then `vdac`=4.
- **Normal line 10.** `vdac`=0 for clocks 0-75 and 4 for clocks 76-1015. `pix_ready` stays 0 for the whole line.
- **Broad line 3.** `vdac`=0 for clocks 0-431, 4 for 432-507, 0 for 508-939, and 4 for 940-1015.
- **Active line 22, pix_valid=1, pix_data=pix_x[3:0]:**
  - `pix_ready` is high for h=168..983 with `pix_x` running 0..815 and `pix_y`=0.
  - `vdac` shows 5,5,5,5,5,5,6..15 repeating; codes 0-4 are clamped to 5.
- **Underrun.** Drop `pix_valid` at line 30, pix_x 100.
  - `vdac`=5 at that position.
  - `underrun`=1 one clock later and stays set.
  - Pulse `underrun_clr` together with another starved cycle: `underrun` stays 1. A lone `underrun_clr` clears it.
- **en drop mid-frame.** Drop `en` at line 100, h 500 for 3 clocks.
  - `vdac`=4 and `pix_ready`=0 while en is low.
  - After en rises, `frame_start` pulses and line 0 equalizing timing restarts.
